// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, state encoding and constants for the memory port arbiter
package mem_arb_pkg;
  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MASK_W = 4;
  localparam logic [MEM_DW-1:0] TIMEOUT_RDATA = 32'h0;
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with data priority and a starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [MASK_W-1:0] i_mask,
  output logic              i_valid,
  output logic [MEM_DW-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [MEM_AW-1:0] d_addr,
  input  logic [MEM_DW-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_mask,
  output logic              d_valid,
  output logic [MEM_DW-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [MEM_DW-1:0] m_wdata,
  output logic [MASK_W-1:0] m_mask,
  input  logic              m_valid,
  input  logic [MEM_DW-1:0] m_rdata,
  output logic              bus_err
);
  localparam int SW = MAX_D_STREAK > 0 ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  arb_state_t state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic streak_max, gnt_i, gnt_d, busy, tmo, fin;
  logic [MEM_DW-1:0] cap;
  assign streak_max = streak == SW'(MAX_D_STREAK);
  assign gnt_i = state == IDLE && i_req && (!d_req || streak_max);
  assign gnt_d = state == IDLE && d_req && !gnt_i;
  assign busy  = state == I_BUSY || state == D_BUSY;
  // tcnt counts BUSY cycles starting at 1, so the match lands on the last allowed cycle
  assign tmo   = busy && !m_valid && TIMEOUT_CYCLES != 0 && tcnt == TW'(TIMEOUT_CYCLES);
  assign fin   = busy && (m_valid || tmo);
  assign cap   = tmo ? TIMEOUT_RDATA : m_we ? '0 : m_rdata;
  // arbitration state, data streak and transaction timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      streak <= '0;
      tcnt   <= '0;
    end else begin
      state  <= gnt_i ? I_BUSY : gnt_d ? D_BUSY : fin ? DONE : state == DONE ? IDLE : state;
      if (gnt_i || (gnt_d && !i_req)) streak <= '0;
      else if (gnt_d && !streak_max) streak <= streak + 1'b1;
      if (gnt_i || gnt_d) tcnt <= TW'(1);
      else if (busy) tcnt <= tcnt + 1'b1;
    end
  end
  // shared-port bank: loaded on grant, held through BUSY, request dropped on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_mask  <= '0;
    end else if (gnt_i) begin
      m_req   <= 1'b1;
      m_we    <= 1'b0;
      m_addr  <= i_addr;
      m_wdata <= '0;
      m_mask  <= i_mask;
    end else if (gnt_d) begin
      m_req   <= 1'b1;
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_mask  <= d_mask;
    end else if (fin) begin
      m_req   <= 1'b0;
    end
  end
  // response bank: one-cycle valid to the owner during DONE, rdata held until the next completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      i_valid <= fin && state == I_BUSY;
      d_valid <= fin && state == D_BUSY;
      if (fin && state == I_BUSY) i_rdata <= cap;
      if (fin && state == D_BUSY) d_rdata <= cap;
      bus_err <= bus_err | tmo;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, completion, starvation, timeout and reset
module tb_mem_port_arbiter;
  logic clk = 0, rst = 0;
  logic i_req = 0, d_req = 0, d_we = 0, m_valid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] i_mask = 0, d_mask = 0;
  logic i_valid, d_valid, m_req, m_we, bus_err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0] m_mask;
  int tests = 0, fails = 0;
  logic [5:0] exp_i_round;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_mask(i_mask), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_valid(m_valid), .m_rdata(m_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_m_req", m_req, 0);
    chk("rst_valids", {i_valid, d_valid}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_m_addr", m_addr, 0);
    rst = 1;
    tick();
    m_valid = 1; m_rdata = 32'h1234;
    tick();
    m_valid = 0;
    tick();
    chk("stray_valids", {i_valid, d_valid}, 0);
    chk("stray_rdata", i_rdata | d_rdata, 0);
    chk("stray_m_req", m_req, 0);
    d_req = 1; d_we = 0; d_addr = 32'h100; d_mask = 4'hf;
    tick();
    chk("ld_m_req", m_req, 1);
    chk("ld_m_addr", m_addr, 32'h100);
    chk("ld_m_we", m_we, 0);
    tick();
    tick();
    chk("ld_wait_valid", d_valid, 0);
    m_valid = 1; m_rdata = 32'hCAFEF00D;
    tick();
    m_valid = 0;
    chk("ld_d_valid", d_valid, 1);
    chk("ld_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("ld_i_valid", i_valid, 0);
    chk("ld_m_req_drop", m_req, 0);
    d_req = 0;
    tick();
    chk("ld_d_valid_pulse", d_valid, 0);
    i_req = 1; i_addr = 32'h2000; i_mask = 4'hf;
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h55; d_mask = 4'h3;
    tick();
    chk("sim_first_addr", m_addr, 32'h300);
    chk("sim_first_we", m_we, 1);
    chk("sim_first_wdata", m_wdata, 32'h55);
    m_valid = 1; m_rdata = 32'hAAAA;
    tick();
    m_valid = 0;
    chk("sim_d_valid", {i_valid, d_valid}, 2'b01);
    chk("sim_store_rdata", d_rdata, 0);
    d_req = 0;
    tick();
    chk("sim_idle_gap", m_addr, 32'h300);
    tick();
    chk("sim_i_addr", m_addr, 32'h2000);
    chk("sim_i_we", {m_we, m_wdata}, 0);
    m_valid = 1; m_rdata = 32'h13579BDF;
    tick();
    m_valid = 0;
    chk("sim_i_valid", {i_valid, d_valid}, 2'b10);
    chk("sim_i_rdata", i_rdata, 32'h13579BDF);
    i_req = 0;
    tick();
    exp_i_round = 6'b010000;
    i_req = 1; i_addr = 32'h4000;
    d_req = 1; d_we = 1;
    for (int r = 0; r < 6; r++) begin
      d_addr = 32'h500 + r;
      tick();
      chk("starve_owner", m_addr, exp_i_round[r] ? 32'h4000 : 32'h500 + r);
      m_valid = 1; m_rdata = 32'hDEAD;
      tick();
      m_valid = 0;
      chk("starve_valids", {i_valid, d_valid}, exp_i_round[r] ? 2'b10 : 2'b01);
      if (exp_i_round[r]) i_req = 0;
      tick();
    end
    d_req = 0;
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h600;
    tick();
    chk("tmo_m_req", m_req, 1);
    for (int c = 0; c < 7; c++) tick();
    chk("tmo_8th_busy", m_req, 1);
    chk("tmo_no_err_yet", bus_err, 0);
    tick();
    chk("tmo_m_req_drop", m_req, 0);
    chk("tmo_d_valid", d_valid, 1);
    chk("tmo_d_rdata", d_rdata, 0);
    chk("tmo_bus_err", bus_err, 1);
    d_req = 0;
    tick();
    tick();
    chk("tmo_sticky", bus_err, 1);
    chk("tmo_pulse_once", d_valid, 0);
    d_req = 1; d_we = 0; d_addr = 32'h700;
    tick();
    chk("rst_mid_busy", m_req, 1);
    #2 rst = 0;
    #1;
    chk("rst_async_m_req", m_req, 0);
    chk("rst_async_err", bus_err, 0);
    d_req = 0;
    m_valid = 1;
    #3 rst = 1;
    tick();
    m_valid = 0;
    tick();
    chk("rst_no_valid", {i_valid, d_valid}, 0);
    i_req = 1; i_addr = 32'h800;
    tick();
    chk("post_rst_grant", {m_req, m_addr}, {1'b1, 32'h800});
    chk("post_rst_err", bus_err, 0);
    m_valid = 1; m_rdata = 32'h0BADBEEF;
    tick();
    m_valid = 0;
    chk("post_rst_i_valid", {i_valid, d_valid}, 2'b10);
    chk("post_rst_i_rdata", i_rdata, 32'h0BADBEEF);
    i_req = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
